lcd_spi_rx: RTL and testbench
=============================

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 The block SHALL have parameter XE_RESET, default 16'd239, giving the column-end value loaded at reset.
REQ-002 The block SHALL have parameter YE_RESET, default 16'd319, giving the row-end value loaded at reset.
REQ-003 clk  input  1  system clock; SHALL be at least 4x the SPI bit clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_clk  input  1  asynchronous SPI bit clock; data sampled on its rising edge.
REQ-006 spi_cs  input  1  asynchronous chip select, active low.
REQ-007 spi_rs  input  1  asynchronous data/command select: 0 = command byte, 1 = data byte.
REQ-008 spi_data  input  1  asynchronous serial data, MSB first.
REQ-009 cmd_valid  output  1  one-cycle pulse per received command byte.
REQ-010 cmd_code  output  8  last command byte; valid while cmd_valid is high.
REQ-011 pix_valid  output  1  one-cycle pulse per received RGB565 pixel.
REQ-012 pix_data  output  16  pixel value, first byte in [15:8].
REQ-013 pix_x, pix_y  output  16 each  pixel column and row for the current pix_valid.
REQ-014 frame_done  output  1  one-cycle pulse, coincident with pix_valid, for the pixel at (xe, ye).
REQ-015 sleep_out, disp_on  output  1 each  panel status flags.
REQ-016 madctl, colmod  output  8 each  last MADCTL and COLMOD parameters.

Function
REQ-017 spi_clk, spi_cs, spi_rs and spi_data SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-018 A bit SHALL be shifted in on each detected 0->1 transition of synchronized spi_clk while synchronized spi_cs is 0; transitions while spi_cs is 1 SHALL be ignored.
REQ-019 The byte SHALL complete on the 8th shifted bit; spi_rs SHALL be captured at that bit.
REQ-020 spi_cs going high with 1-7 bits shifted SHALL discard the partial byte; command context and the pending pixel high byte SHALL be kept.
REQ-021 A command byte (rs = 0) SHALL pulse cmd_valid, reset the parameter index to 0, clear the pixel byte phase, and select the decoder state.
REQ-022 Decoder states: IDLE, CASET, RASET, MADCTL, COLMOD, RAMWR, IGNORE.
- 0x2A -> CASET; 0x2B -> RASET; 0x36 -> MADCTL; 0x3A -> COLMOD.
- 0x2C -> RAMWR; also loads cx = xs, cy = ys.
- 0x11 sets sleep_out; 0x10 clears sleep_out; 0x29 sets disp_on; 0x28 clears disp_on; all four -> IDLE.
- Any other code -> IGNORE.
REQ-023 CASET SHALL take data bytes 0-3 as xs[15:8], xs[7:0], xe[15:8], xe[7:0]; bytes after the 4th SHALL be ignored; RASET SHALL do the same for ys and ye.
REQ-024 MADCTL and COLMOD SHALL latch the first data byte into madctl or colmod and ignore any further bytes.
REQ-025 In RAMWR, data bytes SHALL pair alternately as high then low byte; each low byte SHALL emit pix_valid with pix_data = {high, low}, pix_x = cx, pix_y = cy.
REQ-026 After each pixel, coordinates SHALL advance:
- If cx != xe: cx + 1.
- If cx == xe: cx = xs, and cy = cy + 1, or cy = ys when cy == ye; frame_done pulses when cx == xe and cy == ye.
- Arithmetic SHALL be 16-bit with natural wrap; xs > xe SHALL still compare on equality only.
REQ-027 Data bytes in IDLE or IGNORE SHALL have no effect; RAMWR SHALL persist across spi_cs deassertion until the next command byte.
REQ-028 cmd_valid and pix_valid SHALL assert exactly 4 clk cycles after the rising spi_clk edge carrying bit 0 of the completing byte reaches the pin; they SHALL never assert in the same cycle.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst is 1 at a clk edge, all state SHALL clear:
- Decoder state = IDLE; bit count, parameter index and pixel phase = 0.
- xs = ys = 0; xe = XE_RESET; ye = YE_RESET.
- cmd_valid, pix_valid, frame_done, cmd_code, pix_data, pix_x, pix_y, madctl, colmod, sleep_out, disp_on = 0.
REQ-031 Reset asserted mid-byte or mid-pixel SHALL discard the partial byte and pixel; the first complete byte after reset SHALL decode from IDLE.

Verification
REQ-032 Send cmd 0x11, then cmd 0x29 -> two cmd_valid pulses with codes 0x11 then 0x29; sleep_out = 1; disp_on = 1.
REQ-033 Send CASET 00 28 01 17, RASET 00 35 00 BB, RAMWR, then pixels F800, 07E0 -> pix (0x28,0x35)=F800, then (0x29,0x35)=07E0.
REQ-034 Set window xs = xe = 2, ys = 0, ye = 1; send RAMWR and 3 pixels -> coordinates (2,0), (2,1) with frame_done, then (2,0).
REQ-035 Drop spi_cs after 5 bits of a data byte, then resend the full byte -> exactly one byte is decoded; a pixel high byte sent before the CS drop pairs correctly.
REQ-036 Assert rst mid-RAMWR -> outputs clear; following data bytes produce no pix_valid until a new RAMWR command arrives.

Source files
------------

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive side of a 4-wire LCD SPI link (ST7789-style subset).
// This block samples the SPI pins with the system clock. It assembles bytes
// MSB first, then decodes them into command pulses, panel status flags and
// RGB565 pixels with window-relative coordinates.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   spi_clk       SPI bit clock (async), data taken on its rising edge
//   spi_cs        chip select, active low (async)
//   spi_rs        0 = command byte, 1 = data byte (async)
//   spi_data      serial data, MSB first (async)
//   cmd_valid     one-cycle pulse per command byte, code on cmd_code
//   pix_valid     one-cycle pulse per pixel, value on pix_data at pix_x/pix_y
//   frame_done    pulses with the pixel written at (xe, ye)
//   sleep_out, disp_on, madctl, colmod   panel status
module lcd_spi_rx #(
  parameter logic [15:0] XE_RESET = 16'd239,
  parameter logic [15:0] YE_RESET = 16'd319
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs,
  input  logic        spi_rs,
  input  logic        spi_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        frame_done,
  output logic        sleep_out,
  output logic        disp_on,
  output logic [7:0]  madctl,
  output logic [7:0]  colmod
);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET, S_RASET, S_MADCTL, S_COLMOD, S_RAMWR, S_IGNORE
  } state_t;

  // Synchronizers. r_sclk_d is the previous synchronized clock for edge detect.
  logic r_sclk_m, r_sclk_s, r_sclk_d;
  logic r_cs_m, r_cs_s, r_rs_m, r_rs_s, r_dat_m, r_dat_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_m <= 1'b0; r_sclk_s <= 1'b0; r_sclk_d <= 1'b0;
      r_cs_m   <= 1'b1; r_cs_s   <= 1'b1;
      r_rs_m   <= 1'b0; r_rs_s   <= 1'b0;
      r_dat_m  <= 1'b0; r_dat_s  <= 1'b0;
    end else begin
      r_sclk_m <= spi_clk;  r_sclk_s <= r_sclk_m; r_sclk_d <= r_sclk_s;
      r_cs_m   <= spi_cs;   r_cs_s   <= r_cs_m;
      r_rs_m   <= spi_rs;   r_rs_s   <= r_rs_m;
      r_dat_m  <= spi_data; r_dat_s  <= r_dat_m;
    end
  end

  logic w_sclk_rise;
  assign w_sclk_rise = r_sclk_s & ~r_sclk_d & ~r_cs_s;

  // Byte assembly stage: one-cycle r_byte_vld when the 8th bit lands.
  logic [2:0] r_bcnt;
  logic [6:0] r_sh;
  logic       r_byte_vld, r_byte_rs;
  logic [7:0] r_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt <= 3'd0; r_sh <= 7'd0;
      r_byte_vld <= 1'b0; r_byte_rs <= 1'b0; r_byte <= 8'd0;
    end else begin
      r_byte_vld <= 1'b0;
      if (r_cs_s) begin
        r_bcnt <= 3'd0;                // partial byte dropped on deselect
      end else if (w_sclk_rise) begin
        r_sh <= {r_sh[5:0], r_dat_s};
        if (r_bcnt == 3'd7) begin
          r_byte_vld <= 1'b1;
          r_byte     <= {r_sh, r_dat_s};
          r_byte_rs  <= r_rs_s;
          r_bcnt     <= 3'd0;
        end else begin
          r_bcnt <= r_bcnt + 3'd1;
        end
      end
    end
  end

  // Decode stage: registered state and outputs, next values computed below.
  state_t      r_state, w_state_nx;
  logic [2:0]  r_pidx, w_pidx_nx;
  logic        r_phase, w_phase_nx;
  logic [7:0]  r_hi, w_hi_nx;
  logic [15:0] r_xs, r_xe, r_ys, r_ye, r_cx, r_cy;
  logic [15:0] w_xs_nx, w_xe_nx, w_ys_nx, w_ye_nx, w_cx_nx, w_cy_nx;
  logic        r_cmd_valid, r_pix_valid, r_frame_done, r_sleep, r_disp;
  logic        w_cmd_valid_nx, w_pix_valid_nx, w_frame_done_nx, w_sleep_nx, w_disp_nx;
  logic [7:0]  r_cmd_code, r_madctl, r_colmod;
  logic [7:0]  w_cmd_code_nx, w_madctl_nx, w_colmod_nx;
  logic [15:0] r_pix_data, r_pix_x, r_pix_y;
  logic [15:0] w_pix_data_nx, w_pix_x_nx, w_pix_y_nx;

  always_comb begin
    w_state_nx = r_state;   w_pidx_nx = r_pidx;   w_phase_nx = r_phase;
    w_hi_nx = r_hi;
    w_xs_nx = r_xs; w_xe_nx = r_xe; w_ys_nx = r_ys; w_ye_nx = r_ye;
    w_cx_nx = r_cx; w_cy_nx = r_cy;
    w_cmd_valid_nx = 1'b0; w_pix_valid_nx = 1'b0; w_frame_done_nx = 1'b0;
    w_cmd_code_nx = r_cmd_code;
    w_pix_data_nx = r_pix_data; w_pix_x_nx = r_pix_x; w_pix_y_nx = r_pix_y;
    w_sleep_nx = r_sleep; w_disp_nx = r_disp;
    w_madctl_nx = r_madctl; w_colmod_nx = r_colmod;
    if (r_byte_vld) begin
      if (!r_byte_rs) begin
        w_cmd_valid_nx = 1'b1;
        w_cmd_code_nx  = r_byte;
        w_pidx_nx      = 3'd0;
        w_phase_nx     = 1'b0;
        case (r_byte)
          8'h2A: w_state_nx = S_CASET;
          8'h2B: w_state_nx = S_RASET;
          8'h36: w_state_nx = S_MADCTL;
          8'h3A: w_state_nx = S_COLMOD;
          8'h2C: begin w_state_nx = S_RAMWR; w_cx_nx = r_xs; w_cy_nx = r_ys; end
          8'h11: begin w_state_nx = S_IDLE; w_sleep_nx = 1'b1; end
          8'h10: begin w_state_nx = S_IDLE; w_sleep_nx = 1'b0; end
          8'h29: begin w_state_nx = S_IDLE; w_disp_nx  = 1'b1; end
          8'h28: begin w_state_nx = S_IDLE; w_disp_nx  = 1'b0; end
          default: w_state_nx = S_IGNORE;
        endcase
      end else begin
        case (r_state)
          S_CASET, S_RASET: begin
            // r_pidx saturates at 4 so bytes past the window are dropped
            if (r_pidx != 3'd4) w_pidx_nx = r_pidx + 3'd1;
            case ({r_state == S_RASET, r_pidx})
              4'b0000: w_xs_nx[15:8] = r_byte;
              4'b0001: w_xs_nx[7:0]  = r_byte;
              4'b0010: w_xe_nx[15:8] = r_byte;
              4'b0011: w_xe_nx[7:0]  = r_byte;
              4'b1000: w_ys_nx[15:8] = r_byte;
              4'b1001: w_ys_nx[7:0]  = r_byte;
              4'b1010: w_ye_nx[15:8] = r_byte;
              4'b1011: w_ye_nx[7:0]  = r_byte;
              default: ;
            endcase
          end
          S_MADCTL: if (r_pidx == 3'd0) begin w_madctl_nx = r_byte; w_pidx_nx = 3'd1; end
          S_COLMOD: if (r_pidx == 3'd0) begin w_colmod_nx = r_byte; w_pidx_nx = 3'd1; end
          S_RAMWR: begin
            if (!r_phase) begin
              w_hi_nx    = r_byte;
              w_phase_nx = 1'b1;
            end else begin
              w_phase_nx     = 1'b0;
              w_pix_valid_nx = 1'b1;
              w_pix_data_nx  = {r_hi, r_byte};
              w_pix_x_nx     = r_cx;
              w_pix_y_nx     = r_cy;
              if (r_cx == r_xe) begin
                w_cx_nx = r_xs;
                if (r_cy == r_ye) begin
                  w_cy_nx = r_ys;
                  w_frame_done_nx = 1'b1;
                end else begin
                  w_cy_nx = r_cy + 16'd1;
                end
              end else begin
                w_cx_nx = r_cx + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE; r_pidx <= 3'd0; r_phase <= 1'b0; r_hi <= 8'd0;
      r_xs <= 16'd0; r_xe <= XE_RESET; r_ys <= 16'd0; r_ye <= YE_RESET;
      r_cx <= 16'd0; r_cy <= 16'd0;
      r_cmd_valid <= 1'b0; r_pix_valid <= 1'b0; r_frame_done <= 1'b0;
      r_cmd_code <= 8'd0; r_pix_data <= 16'd0; r_pix_x <= 16'd0; r_pix_y <= 16'd0;
      r_sleep <= 1'b0; r_disp <= 1'b0; r_madctl <= 8'd0; r_colmod <= 8'd0;
    end else begin
      r_state <= w_state_nx; r_pidx <= w_pidx_nx; r_phase <= w_phase_nx; r_hi <= w_hi_nx;
      r_xs <= w_xs_nx; r_xe <= w_xe_nx; r_ys <= w_ys_nx; r_ye <= w_ye_nx;
      r_cx <= w_cx_nx; r_cy <= w_cy_nx;
      r_cmd_valid <= w_cmd_valid_nx; r_pix_valid <= w_pix_valid_nx;
      r_frame_done <= w_frame_done_nx;
      r_cmd_code <= w_cmd_code_nx; r_pix_data <= w_pix_data_nx;
      r_pix_x <= w_pix_x_nx; r_pix_y <= w_pix_y_nx;
      r_sleep <= w_sleep_nx; r_disp <= w_disp_nx;
      r_madctl <= w_madctl_nx; r_colmod <= w_colmod_nx;
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign frame_done = r_frame_done;
  assign sleep_out  = r_sleep;
  assign disp_on    = r_disp;
  assign madctl     = r_madctl;
  assign colmod     = r_colmod;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Testbench for lcd_spi_rx: directed scenarios plus randomized command/data
// traffic, checked by a scoreboard fed from a byte-level panel model.
module tb_lcd_spi_rx;

  logic clk = 1'b0;
  logic rst, spi_clk, spi_cs, spi_rs, spi_data;
  logic cmd_valid, pix_valid, frame_done, sleep_out, disp_on;
  logic [7:0] cmd_code, madctl, colmod;
  logic [15:0] pix_data, pix_x, pix_y;

  lcd_spi_rx dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_rs(spi_rs),
    .spi_data(spi_data), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_done(frame_done), .sleep_out(sleep_out), .disp_on(disp_on),
    .madctl(madctl), .colmod(colmod)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    bit          is_pix;
    logic [7:0]  code;
    logic [15:0] data, x, y;
    bit          fd;
    int          rise;
  } ev_t;
  ev_t exp_q[$];

  // Panel model: meaning of a data byte depends on the last command and on
  // how many data bytes followed it.
  logic [7:0]  m_cmd, m_hi, m_madctl, m_colmod;
  int          m_np;
  logic [15:0] m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
  bit          m_sleep, m_disp;

  task automatic model_reset();
    m_cmd = 8'h00; m_np = 0; m_hi = 8'h00;
    m_xs = 16'd0; m_xe = 16'd239; m_ys = 16'd0; m_ye = 16'd319;
    m_cx = 16'd0; m_cy = 16'd0;
    m_sleep = 0; m_disp = 0; m_madctl = 8'h00; m_colmod = 8'h00;
  endtask

  task automatic model_byte(input bit rs, input logic [7:0] b);
    ev_t e;
    e.is_pix = 0; e.code = b; e.data = 16'd0; e.x = 16'd0; e.y = 16'd0;
    e.fd = 0; e.rise = cyc;
    if (!rs) begin
      exp_q.push_back(e);
      m_cmd = b; m_np = 0;
      if (b == 8'h2C) begin m_cx = m_xs; m_cy = m_ys; end
      if (b == 8'h11) m_sleep = 1;
      if (b == 8'h10) m_sleep = 0;
      if (b == 8'h29) m_disp = 1;
      if (b == 8'h28) m_disp = 0;
    end else begin
      case (m_cmd)
        8'h2A: case (m_np)
                 0: m_xs[15:8] = b; 1: m_xs[7:0] = b;
                 2: m_xe[15:8] = b; 3: m_xe[7:0] = b;
                 default: ;
               endcase
        8'h2B: case (m_np)
                 0: m_ys[15:8] = b; 1: m_ys[7:0] = b;
                 2: m_ye[15:8] = b; 3: m_ye[7:0] = b;
                 default: ;
               endcase
        8'h36: if (m_np == 0) m_madctl = b;
        8'h3A: if (m_np == 0) m_colmod = b;
        8'h2C: if (m_np % 2 == 0) m_hi = b;
               else begin
                 e.is_pix = 1; e.data = {m_hi, b}; e.x = m_cx; e.y = m_cy;
                 e.fd = (m_cx == m_xe) && (m_cy == m_ye);
                 exp_q.push_back(e);
                 if (m_cx == m_xe) begin
                   m_cx = m_xs;
                   m_cy = (m_cy == m_ye) ? m_ys : m_cy + 16'd1;
                 end else m_cx = m_cx + 16'd1;
               end
        default: ;
      endcase
      m_np++;
    end
  endtask

  // Scoreboard monitor, sampling on the falling clock edge.
  always @(negedge clk) begin
    ev_t e;
    if (cmd_valid && pix_valid) chk("cmd_pix_overlap", 32'd1, 32'd0);
    if (frame_done && !pix_valid) chk("frame_done_alone", 32'd1, 32'd0);
    if (cmd_valid || pix_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, cmd_valid, pix_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 32'(pix_valid), 32'(e.is_pix));
        chk("latency", 32'(cyc - e.rise), 32'd4);
        if (e.is_pix) begin
          chk("pix_data", 32'(pix_data), 32'(e.data));
          chk("pix_x", 32'(pix_x), 32'(e.x));
          chk("pix_y", 32'(pix_y), 32'(e.y));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
        end else begin
          chk("cmd_code", 32'(cmd_code), 32'(e.code));
        end
      end
    end
  end

  // SPI driver: bit period of four system clocks, edges placed mid-cycle.
  task automatic send_bits(input bit rs, input logic [7:0] b, input int nbits, input bit model);
    if (spi_cs) begin
      spi_cs = 1'b0;
      repeat (2) @(negedge clk);
    end
    spi_rs = rs;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk); spi_data = b[i];
      @(negedge clk); spi_clk = 1'b1;
      if (i == 0 && model) model_byte(rs, b);
      repeat (2) @(negedge clk); spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send_bits(rs, b, 8, 1'b1);
  endtask

  task automatic cs_high();
    @(negedge clk); spi_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_status();
    repeat (3) @(negedge clk);
    chk("sleep_out", 32'(sleep_out), 32'(m_sleep));
    chk("disp_on", 32'(disp_on), 32'(m_disp));
    chk("madctl", 32'(madctl), 32'(m_madctl));
    chk("colmod", 32'(colmod), 32'(m_colmod));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cmd_code", 32'(cmd_code), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_pix_xy", {pix_x, pix_y}, 32'd0);
    chk("rst_flags", {28'd0, sleep_out, disp_on, 2'b00}, 32'd0);
    chk("rst_regs", {16'd0, madctl, colmod}, 32'd0);
  endtask

  task automatic send_window(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    send_byte(0, c);
    send_byte(1, s[15:8]); send_byte(1, s[7:0]);
    send_byte(1, e[15:8]); send_byte(1, e[7:0]);
  endtask

  initial begin
    logic [7:0] cmds [13];
    logic [7:0] c;
    int nb;
    cmds = '{8'h2A, 8'h2B, 8'h2C, 8'h36, 8'h3A, 8'h11, 8'h10, 8'h29, 8'h28,
             8'h00, 8'h01, 8'hFF, 8'hC5};
    rst = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_rs = 1'b0; spi_data = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Sleep out, display on.
    send_byte(0, 8'h11); send_byte(0, 8'h29);
    check_status();

    // Window and two pixels, then MADCTL/COLMOD with extra bytes.
    send_window(8'h2A, 16'h0028, 16'h0117);
    send_window(8'h2B, 16'h0035, 16'h00BB);
    send_byte(0, 8'h2C);
    send_byte(1, 8'hF8); send_byte(1, 8'h00);
    send_byte(1, 8'h07); send_byte(1, 8'hE0);
    cs_high();
    send_byte(0, 8'h36); send_byte(1, 8'hA5); send_byte(1, 8'h5A);
    send_byte(0, 8'h3A); send_byte(1, 8'h55); send_byte(1, 8'h66);
    check_status();

    // One-column window, two rows: wrap and frame_done.
    send_window(8'h2A, 16'd2, 16'd2);
    send_window(8'h2B, 16'd0, 16'd1);
    send_byte(0, 8'h2C);
    for (int i = 0; i < 6; i++) send_byte(1, 8'(8'h10 + i));

    // Partial byte dropped by CS; high byte survives; RAMWR persists over CS.
    send_byte(1, 8'hAB);
    send_bits(1, 8'hCD, 5, 1'b0);
    cs_high();
    send_byte(1, 8'hCD);
    cs_high();

    // Reset in the middle of a pixel.
    send_byte(0, 8'h2C);
    send_byte(1, 8'h12);
    do_reset();
    send_byte(1, 8'h34); send_byte(1, 8'h56); send_byte(1, 8'h78);
    check_status();

    // Full row at reset-default width: wraps at column 239.
    send_byte(0, 8'h2C);
    for (int i = 0; i < 484; i++) send_byte(1, 8'(i * 7));

    // Random traffic.
    for (int op = 0; op < 40; op++) begin
      c = cmds[$urandom_range(0, 12)];
      if ($urandom_range(0, 5) == 0) begin
        send_bits(1, 8'($urandom), $urandom_range(1, 7), 1'b0);
        cs_high();
      end
      send_byte(0, c);
      nb = (c == 8'h2C) ? $urandom_range(0, 12) : $urandom_range(0, 5);
      for (int k = 0; k < nb; k++) begin
        if ((c == 8'h2A || c == 8'h2B) && k < 4)
          send_byte(1, (k % 2 == 0) ? 8'h00 : 8'($urandom_range(0, 4) + (k == 3 ? 2 : 0)));
        else
          send_byte(1, 8'($urandom));
        if ($urandom_range(0, 7) == 0) cs_high();
      end
      check_status();
    end

    repeat (10) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
